// File: rtl/alu_cmd_issue_if.sv
// Command and result handshake bundle for alu_cmd_issue.
// slave is the issue stage side, master is the producer/consumer side.
interface alu_cmd_issue_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [3:0]            cmd_func;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ovf;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_func,
    output cmd_ready,
    output res_valid, res_data, res_ovf,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_func,
    input  cmd_ready,
    input  res_valid, res_data, res_ovf,
    output res_ready
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Issue/retire stage around a combinational ALU: command FIFO,
// one-entry result buffer and saturating overflow counter.
module alu_cmd_issue #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  alu_cmd_issue_if.slave           bus,
  output logic [DATA_WIDTH-1:0]    alu_a,
  output logic [DATA_WIDTH-1:0]    alu_b,
  output logic [3:0]               alu_func,
  input  logic [DATA_WIDTH-1:0]    alu_c,
  input  logic                     alu_ovf,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count,
  output logic                     busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [3:0]            func;
  } cmd_t;

  cmd_t                  mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ovf;
  logic                  push;
  logic                  fire;
  logic                  not_empty;
  cmd_t                  head;

  assign not_empty     = (count != '0);
  assign bus.cmd_ready = reset_n && (count != FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign fire          = not_empty && (!res_valid || bus.res_ready);
  assign head          = mem[rd_ptr];

  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_ovf   = res_ovf;
  assign busy          = not_empty || res_valid;

  // Present the FIFO head to the ALU, or a clear op when idle.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_func = 4'b1111;
    if (not_empty) begin
      alu_a    = head.a;
      alu_b    = head.b;
      alu_func = head.func;
    end
  end

  // Command storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, func: bus.cmd_func};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result buffer capture and release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
    end else if (fire) begin
      res_valid <= 1'b1;
      res_data  <= alu_c;
      res_ovf   <= alu_ovf;
    end else if (res_valid && bus.res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Saturating count of captured overflowing results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (fire && alu_ovf && !(&ovf_count)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Randomized lockstep bench for alu_cmd_issue with a queue model.
// The bench also plays the ALU.
module tb_alu_cmd_issue;
  localparam int DW   = 16;
  localparam int D    = 4;
  localparam int OW   = 2;
  localparam int OMAX = (1 << OW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issue_if #(.DATA_WIDTH(DW)) bus ();

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_c;
  logic [3:0]    alu_func;
  logic          alu_ovf;
  logic [OW-1:0] ovf_count;
  logic          busy;

  alu_cmd_issue #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(D),
    .OVF_CNT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_func(alu_func),
    .alu_c(alu_c),
    .alu_ovf(alu_ovf),
    .ovf_count(ovf_count),
    .busy(busy)
  );

  // ALU: 0 add, 1 sub, 2 or, 3 and, 4 xor, 15 clear
  function automatic logic [DW:0] alu_fn(
    input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b
  );
    logic [DW-1:0] c;
    logic o;
    c = '0;
    o = 1'b0;
    case (f)
      4'd0: begin
        c = a + b;
        o = (a[DW-1] == b[DW-1]) && (c[DW-1] != a[DW-1]);
      end
      4'd1: begin
        c = a - b;
        o = (a[DW-1] != b[DW-1]) && (c[DW-1] != a[DW-1]);
      end
      4'd2: c = a | b;
      4'd3: c = a & b;
      4'd4: c = a ^ b;
      default: c = '0;
    endcase
    return {o, c};
  endfunction

  always_comb {alu_ovf, alu_c} = alu_fn(alu_func, alu_a, alu_b);

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    f;
  } cmd_t;

  cmd_t q[$];
  cmd_t pend[$];
  bit            m_rv;
  bit            m_ro;
  logic [DW-1:0] m_rd;
  int            m_cnt;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            chk_en = 0;

  task automatic check(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic add_cmd(
    input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f
  );
    cmd_t c;
    c.a = a;
    c.b = b;
    c.f = f;
    pend.push_back(c);
  endtask

  task automatic step(input bit vgate, input bit rr, input bit rst);
    bit v;
    bit rdy;
    bit fire;
    cmd_t c;
    logic [DW:0] r;
    v = vgate && (pend.size() != 0);
    c.a = '0;
    c.b = '0;
    c.f = '0;
    if (v) c = pend[0];
    @(negedge clk);
    bus.cmd_valid = v;
    bus.cmd_a     = c.a;
    bus.cmd_b     = c.b;
    bus.cmd_func  = c.f;
    bus.res_ready = rr;
    reset_n       = rst;
    #1;
    rdy = rst && (q.size() < D);
    if (chk_en) begin
      check("cmd_ready", 32'(bus.cmd_ready), 32'(rdy));
      check("res_valid", 32'(bus.res_valid), 32'(m_rv));
      check("res_data", 32'(bus.res_data), 32'(m_rd));
      check("res_ovf", 32'(bus.res_ovf), 32'(m_ro));
      check("ovf_count", 32'(ovf_count), 32'(m_cnt));
      check("busy", 32'(busy), 32'((q.size() != 0) || m_rv));
      check("alu_a", 32'(alu_a), q.size() != 0 ? 32'(q[0].a) : 32'd0);
      check("alu_b", 32'(alu_b), q.size() != 0 ? 32'(q[0].b) : 32'd0);
      check("alu_func", 32'(alu_func), q.size() != 0 ? 32'(q[0].f) : 32'hF);
    end
    fire = (q.size() != 0) && (!m_rv || rr);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_rv  = 0;
      m_ro  = 0;
      m_rd  = '0;
      m_cnt = 0;
    end else begin
      if (fire) begin
        r = alu_fn(q[0].f, q[0].a, q[0].b);
        void'(q.pop_front());
        m_rd = r[DW-1:0];
        m_ro = r[DW];
        m_rv = 1;
        if (r[DW] && m_cnt < OMAX) m_cnt++;
      end else if (m_rv && rr) begin
        m_rv = 0;
      end
      if (v && rdy) begin
        q.push_back(c);
        void'(pend.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0);
    pend.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((pend.size() != 0 || q.size() != 0 || m_rv) && n < 60) begin
      step(1'b1, 1'b1, 1'b1);
      n++;
    end
    check(tag, 32'(n < 60), 32'd1);
  endtask

  logic [3:0] funcs [6];

  initial begin
    funcs[0] = 4'd0; funcs[1] = 4'd1; funcs[2] = 4'd2;
    funcs[3] = 4'd3; funcs[4] = 4'd4; funcs[5] = 4'd15;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_func  = '0;
    bus.res_ready = 1'b0;

    do_reset();
    chk_en = 1;
    do_reset();

    // idle after reset
    repeat (10) step(1'b0, 1'b1, 1'b1);

    // single add with overflow
    add_cmd(16'h7FFF, 16'h0001, 4'd0);
    drain("add_drain");
    step(1'b0, 1'b1, 1'b1);
    check("add_cnt", 32'(ovf_count), 32'd1);

    // streaming sub then and
    add_cmd(16'h8000, 16'h0001, 4'd1);
    add_cmd(16'hF0F0, 16'h0FF0, 4'd3);
    drain("stream_drain");

    // backpressure: depth+1 accepted, then release
    do_reset();
    for (int i = 0; i < 7; i++) add_cmd(DW'(i), 16'h0000, 4'd2);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    #1;
    check("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
    check("bp_head_data", 32'(bus.res_data), 32'd0);
    drain("bp_drain");

    // saturation
    do_reset();
    for (int i = 0; i < 5; i++) add_cmd(16'h7FFF, 16'h7FFF, 4'd0);
    drain("sat_drain");
    #1;
    check("sat_cnt", 32'(ovf_count), 32'(OMAX));

    // reset mid-operation
    for (int i = 0; i < 3; i++) add_cmd(16'h1234, DW'(i), 4'd0);
    repeat (4) step(1'b1, 1'b0, 1'b1);
    do_reset();
    #1;
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (6) step(1'b0, 1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (pend.size() < 2)
        add_cmd(DW'($urandom), DW'($urandom), funcs[$urandom_range(0, 5)]);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 199) != 0);
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
Issue and retire stage wrapped around the combinational ALU (FuncCode, A, B in; C, OverflowFlag out). It accepts operation commands over a valid/ready interface and buffers them in a small in-order FIFO. It drives the FIFO head onto the ALU inputs, registers the ALU result into a one-entry output buffer with its own valid/ready handshake, and keeps a saturating count of overflowing results for the datapath controller.

Parameters:
- DATA_WIDTH, 16, operand/result width; must equal the ALU data_width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.
- OVF_CNT_WIDTH, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready.
- cmd_a  in  DATA_WIDTH  operand A.
- cmd_b  in  DATA_WIDTH  operand B.
- cmd_func  in  4  ALU function code.
- alu_a  out  DATA_WIDTH  to ALU A.
- alu_b  out  DATA_WIDTH  to ALU B.
- alu_func  out  4  to ALU FuncCode.
- alu_c  in  DATA_WIDTH  from ALU C.
- alu_ovf  in  1  from ALU OverflowFlag.
- res_valid  out  1  result buffer holds a result.
- res_ready  in  1  consumer takes the result on an edge where res_valid && res_ready.
- res_data  out  DATA_WIDTH  registered result.
- res_ovf  out  1  registered overflow flag of res_data.
- ovf_count  out  OVF_CNT_WIDTH  number of results captured with overflow; saturates.
- busy  out  1  FIFO non-empty or res_valid.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - FIFO emptied; result buffer emptied.
  - res_valid=0, res_data=0, res_ovf=0, ovf_count=0.
  - cmd_ready=0 while reset_n is low; cmd_ready=1 on the first cycle after release.
  - A reset mid-operation drops all queued and buffered commands and results. None of them appear after release.
- FIFO:
  - Circular buffer with read/write pointers and a count of 0..FIFO_DEPTH.
  - cmd_ready = (count != FIFO_DEPTH). No same-cycle pass-through when full, even if a pop happens that cycle.
  - Push: on cmd_valid && cmd_ready, write {cmd_a, cmd_b, cmd_func} at wr_ptr.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge leave count unchanged.
- ALU drive (combinational from FIFO head):
  - Non-empty: alu_a/alu_b/alu_func = head entry.
  - Empty: alu_a=0, alu_b=0, alu_func=4'b1111 (clear op).
- Capture/pop: fire = (count != 0) && (!res_valid || res_ready). On a fire edge:
  - Pop the head.
  - res_data<=alu_c, res_ovf<=alu_ovf, res_valid<=1.
  - If alu_ovf=1 and ovf_count is not all ones, ovf_count increments by 1.
- Result buffer:
  - On res_valid && res_ready without fire: res_valid<=0. res_data and res_ovf hold their last values.
  - While res_valid && !res_ready: res_data and res_ovf are stable.
- Latency: command accepted at edge k into an empty FIFO with the result buffer free → res_valid=1 after edge k+1.
- Throughput: 1 result/cycle when cmd_valid=1 and res_ready=1 continuously.
- Ordering: results leave strictly in command-acceptance order.
- Capacity: FIFO_DEPTH+1 commands can be outstanding under full backpressure.
- ovf_count is never cleared except by reset.
- busy = (count != 0) || res_valid.

Test Plan:
- Single ADD: cmd_a=16'h7FFF, cmd_b=16'h0001, func=4'b0000 accepted at edge k, res_ready=1 -> res_valid after edge k+1, res_data=16'h8000, res_ovf=1, ovf_count=1; res_valid=0 and busy=0 the following cycle.
- Streaming: back-to-back SUB 16'h8000-16'h0001 then AND 16'hF0F0&16'h0FF0, res_ready=1 -> consecutive results 16'h7FFF (res_ovf=1) then 16'h00F0 (res_ovf=0); cmd_ready stays 1.
- Backpressure (FIFO_DEPTH=4): res_ready=0, offer 7 commands each with cmd_a=i, func=4'b0010 -> exactly 5 accepted, cmd_ready=0 afterwards; raise res_ready -> res_data 0,1,2,3,4 on 5 consecutive cycles, stalled commands then enter.
- Saturation (OVF_CNT_WIDTH=2): 5 ADDs of 16'h7FFF+16'h7FFF -> each res_ovf=1, ovf_count 1,2,3,3,3.
- Reset mid-operation: 3 commands queued with res_ready=0, reset_n=0 for one edge -> cmd_ready=0 during reset; after release res_valid=0, ovf_count=0, busy=0, cmd_ready=1; no stale result appears when res_ready is raised.
- Idle: FIFO empty after reset -> alu_a=0, alu_b=0, alu_func=4'b1111, res_valid=0 held for 10 cycles.
